// File: rtl/bomb_pkg.sv
// rtl/bomb_pkg.sv - shared bomb slot encoding and default sprite geometry
package bomb_pkg;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_ARMED   = 2'd1,
    SLOT_PENDING = 2'd2
  } slot_state_t;

  localparam int DEF_COORD_W = 10;
  localparam int DEF_BOMB_W  = 16;
  localparam int DEF_BOMB_H  = 16;

endpackage

// File: rtl/bomb_slot.sv
// rtl/bomb_slot.sv - one bomb slot: FREE/ARMED/PENDING state, origin and fuse timer
module bomb_slot
  import bomb_pkg::*;
#(
  parameter int COORD_W     = DEF_COORD_W,
  parameter int TIMER_W     = 29,
  parameter int FUSE_CYCLES = 400000000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               arm,
  input  logic [COORD_W-1:0] arm_x,
  input  logic [COORD_W-1:0] arm_y,
  input  logic               detonate_match,
  input  logic               free,
  output logic [1:0]         state,
  output logic [1:0]         next_state,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y
);

  localparam logic [TIMER_W-1:0] FUSE_LAST = TIMER_W'(FUSE_CYCLES - 1);

  slot_state_t        state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    x_d     = x_q;
    y_d     = y_q;
    unique case (state_q)
      SLOT_FREE: begin
        if (arm) begin
          state_d = SLOT_ARMED;
          timer_d = '0;
          x_d     = arm_x;
          y_d     = arm_y;
        end
      end
      SLOT_ARMED: begin
        // Expiry and remote detonation collapse into the same single PENDING
        if (detonate_match || timer_q == FUSE_LAST) state_d = SLOT_PENDING;
        else timer_d = timer_q + TIMER_W'(1);
      end
      SLOT_PENDING: begin
        if (free) state_d = SLOT_FREE;
      end
      default: state_d = SLOT_FREE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SLOT_FREE;
      timer_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign state      = state_q;
  assign next_state = state_d;
  assign x          = x_q;
  assign y          = y_q;

endmodule

// File: rtl/bomb_pool.sv
// rtl/bomb_pool.sv - multi-slot bomb manager: placement, fuses, detonation, expiry queue, pixel query
module bomb_pool
  import bomb_pkg::*;
#(
  parameter int  NUM_SLOTS   = 6,
  parameter int  COORD_W     = DEF_COORD_W,
  parameter int  TIMER_W     = 29,
  parameter int  FUSE_CYCLES = 400000000,
  parameter int  BOMB_W      = DEF_BOMB_W,
  parameter int  BOMB_H      = DEF_BOMB_H,
  localparam int CNT_W       = $clog2(NUM_SLOTS + 1)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               place_btn,
  input  logic [CNT_W-1:0]   max_active,
  input  logic [COORD_W-1:0] b_x,
  input  logic [COORD_W-1:0] b_y,
  input  logic               det_req,
  input  logic [COORD_W-1:0] det_x,
  input  logic [COORD_W-1:0] det_y,
  input  logic [COORD_W-1:0] v_x,
  input  logic [COORD_W-1:0] v_y,
  output logic               place_ack,
  output logic               place_nack,
  output logic               explode_valid,
  input  logic               explode_ready,
  output logic [COORD_W-1:0] exploding_bomb_x,
  output logic [COORD_W-1:0] exploding_bomb_y,
  output logic               bomb_on,
  output logic [COORD_W-1:0] bomb_x,
  output logic [COORD_W-1:0] bomb_y,
  output logic [CNT_W-1:0]   active_count
);

  localparam int XW = COORD_W + 1;

  logic [1:0]           slot_state [NUM_SLOTS];
  logic [1:0]           slot_next  [NUM_SLOTS];
  logic [COORD_W-1:0]   slot_x     [NUM_SLOTS];
  logic [COORD_W-1:0]   slot_y     [NUM_SLOTS];
  logic [NUM_SLOTS-1:0] arm, free_strobe, det_match, free_1h, pend_1h;
  logic                 free_found, dup, hit_found, btn_q, place_edge, accept, handshake;
  logic [COORD_W-1:0]   pend_x, pend_y, hit_x, hit_y;
  logic [CNT_W-1:0]     count_d;

  // Descending scan so the lowest index wins every priority encoder
  always_comb begin
    free_found = 1'b0;
    free_1h    = '0;
    pend_1h    = '0;
    pend_x     = '0;
    pend_y     = '0;
    dup        = 1'b0;
    hit_found  = 1'b0;
    hit_x      = '0;
    hit_y      = '0;
    det_match  = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      det_match[i] = det_req && slot_x[i] == det_x && slot_y[i] == det_y;
      if (slot_state[i] == SLOT_FREE) begin
        free_found = 1'b1;
        free_1h    = '0;
        free_1h[i] = 1'b1;
      end else if (slot_x[i] == b_x && slot_y[i] == b_y) begin
        dup = 1'b1;
      end
      if (slot_state[i] == SLOT_PENDING) begin
        pend_1h    = '0;
        pend_1h[i] = 1'b1;
        pend_x     = slot_x[i];
        pend_y     = slot_y[i];
      end
      // One extra bit keeps sprites at the right/bottom edge from wrapping
      if (slot_state[i] == SLOT_ARMED &&
          {1'b0, v_x} >= {1'b0, slot_x[i]} && {1'b0, v_x} <= {1'b0, slot_x[i]} + XW'(BOMB_W - 1) &&
          {1'b0, v_y} >= {1'b0, slot_y[i]} && {1'b0, v_y} <= {1'b0, slot_y[i]} + XW'(BOMB_H - 1)) begin
        hit_found = 1'b1;
        hit_x     = slot_x[i];
        hit_y     = slot_y[i];
      end
    end
  end

  assign explode_valid    = |pend_1h;
  assign exploding_bomb_x = pend_x;
  assign exploding_bomb_y = pend_y;
  assign handshake        = explode_valid && explode_ready;
  assign free_strobe      = handshake ? pend_1h : '0;
  assign place_edge       = place_btn && !btn_q;
  assign accept           = place_edge && (active_count < max_active) && free_found && !dup;
  assign arm              = accept ? free_1h : '0;

  always_comb begin
    count_d = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (slot_next[i] != SLOT_FREE) count_d = count_d + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_slot
    bomb_slot #(
      .COORD_W    (COORD_W),
      .TIMER_W    (TIMER_W),
      .FUSE_CYCLES(FUSE_CYCLES)
    ) u_slot (
      .clk           (clk),
      .reset_n       (reset_n),
      .arm           (arm[g]),
      .arm_x         (b_x),
      .arm_y         (b_y),
      .detonate_match(det_match[g]),
      .free          (free_strobe[g]),
      .state         (slot_state[g]),
      .next_state    (slot_next[g]),
      .x             (slot_x[g]),
      .y             (slot_y[g])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_q        <= 1'b0;
      place_ack    <= 1'b0;
      place_nack   <= 1'b0;
      active_count <= '0;
      bomb_on      <= 1'b0;
      bomb_x       <= '0;
      bomb_y       <= '0;
    end else begin
      btn_q        <= place_btn;
      place_ack    <= accept;
      place_nack   <= place_edge && !accept;
      active_count <= count_d;
      bomb_on      <= hit_found;
      if (hit_found) begin
        bomb_x <= hit_x;
        bomb_y <= hit_y;
      end
    end
  end

endmodule

// File: doc/bomb_pool.md
Name: bomb_pool

Overview:
Parametrised multi-slot bomb manager for the Bomberman datapath. Places bombs at the player location on a debounced button edge and runs an independent fuse timer per slot. Supports remote detonation by coordinate, queues expiries to the explosion logic through a valid/ready handshake, and answers the VGA pixel query with a registered hit and the origin of the hit sprite.

Parameters:
NUM_SLOTS, 6, number of bomb slots (1..16)
COORD_W, 10, pixel coordinate width
TIMER_W, 29, fuse counter width
FUSE_CYCLES, 400000000, clocks from placement to expiry (1..2^TIMER_W-1)
BOMB_W, 16, sprite width in pixels
BOMB_H, 16, sprite height in pixels

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
place_btn  in  1  bomb button, level, already debounced
max_active  in  $clog2(NUM_SLOTS+1)  runtime bomb capacity (power-up level)
b_x, b_y  in  COORD_W each  Bomberman top-left pixel
det_req  in  1  remote detonation strobe
det_x, det_y  in  COORD_W each  detonation target coordinates
v_x, v_y  in  COORD_W each  current pixel
place_ack  out  1  one-cycle pulse: bomb placed
place_nack  out  1  one-cycle pulse: placement refused
explode_valid  out  1  expiry event pending
explode_ready  in  1  explosion logic accepts event
exploding_bomb_x, exploding_bomb_y  out  COORD_W each  origin of presented event
bomb_on  out  1  registered: pixel inside an ARMED sprite
bomb_x, bomb_y  out  COORD_W each  registered origin of hit sprite
active_count  out  $clog2(NUM_SLOTS+1)  number of ARMED plus PENDING slots

Behaviour:
- Reset (async, reset_n=0): all slots FREE, timers 0, btn_q=0, and every output 0.
- Per-slot state: FREE, ARMED, PENDING. Each slot stores x, y and a timer.
- Placement fires when place_btn=1 and btn_q=0 (rising edge; btn_q is the registered place_btn).
  - Accept when all hold: active_count < max_active; a FREE slot exists; no ARMED or PENDING slot has x==b_x and y==b_y.
  - On accept, the lowest-index FREE slot becomes ARMED with timer=0 and coords=b_x,b_y; place_ack=1 next cycle.
  - On refuse, place_nack=1 next cycle.
  - Only one placement per edge; holding the button never re-fires.
- Fuse:
  - An ARMED slot's timer increments every clock.
  - When timer==FUSE_CYCLES-1, the slot is PENDING at the next edge, i.e. exactly FUSE_CYCLES clocks after its ARMED edge.
  - The timer freezes in PENDING.
- Detonation: on det_req=1, every ARMED slot whose coords match det_x,det_y becomes PENDING next edge, regardless of timer. If no slot matches, there is no effect.
- Event queue:
  - explode_valid=|PENDING. exploding_bomb_x/y are the coords of the lowest-index PENDING slot, combinational from slot registers.
  - Handshake completes when explode_valid and explode_ready are both 1; that slot becomes FREE at the edge.
  - Valid and data stay stable while ready=0. One event per cycle. Simultaneous expiries are drained in index order.
- Same-cycle rules (all decisions use pre-edge state):
  - A slot freed by a handshake is not placeable until the next cycle.
  - Expiry and detonation on the same slot yield a single PENDING.
  - A placement edge together with a handshake evaluates the capacity check on the pre-edge active_count.
- active_count is registered and updated every edge from the next slot states (counts ARMED plus PENDING).
- Pixel query: hit_k = ARMED_k && v_x>=x_k && v_x<=x_k+BOMB_W-1 && v_y>=y_k && v_y<=y_k+BOMB_H-1.
  - Comparisons use COORD_W+1 bits, so there is no wrap at the right or bottom edge.
  - Lowest-index hit wins. bomb_on, bomb_x and bomb_y are registered with 1-cycle latency.
  - With no hit, bomb_on=0 and bomb_x/bomb_y hold their previous value.
  - PENDING bombs are not drawn.
- Lowering max_active below active_count frees nothing; it only refuses new placements.

Decomposition:
- Shared package bomb_pkg holds the slot-state encoding (FREE=2'd0, ARMED=2'd1, PENDING=2'd2) and the default BOMB_W/BOMB_H/COORD_W constants, which are reused by the ROM and explosion blocks.
- One sub-module, bomb_slot, instantiated NUM_SLOTS times. It holds state, coords and timer, and takes arm, detonate_match and free strobes. Pool-level priority encoders select the free slot, the pending slot and the pixel hit.

Test Plan:
- FUSE_CYCLES=10, place at (32,48) → place_ack next cycle; explode_valid rises exactly 10 clocks after ARMED; with ready=1, exploding_bomb=(32,48); slot FREE; active_count returns to 0.
- Hold place_btn for 50 cycles → exactly one place_ack. A second edge at the same (32,48) → place_nack.
- max_active=2, three edges at distinct coords → ack, ack, nack. Raise max_active to 3 → the next edge acks.
- Two bombs expire in the same cycle, ready=0 for 5 cycles → valid held with slot-0 coords stable. Then ready=1 → slot-0 then slot-1 coords on consecutive cycles.
- det_req at (64,64) with bombs at (64,64) timer=3 and (80,64) → only the first goes PENDING next edge; a det_req with no match changes nothing.
- Overlapping bombs at (100,100) slot 0 and (108,100) slot 1, pixel (110,105) → bomb_on=1, bomb_x/bomb_y=(100,100) one cycle later. Pixel (116,100) → (108,100). Assert reset_n mid-fuse → all outputs 0 immediately.
